// File: rtl/beat_sequencer_ctrl.sv
// beat_sequencer_ctrl
// Playback controller for the beat-indexed song ROMs. Pad pulses select a
// track and restart it from beat 0; a speed-scaled divider advances the beat
// index. The controller also drives the active ROM's enable and the shared
// pause line, and it pulses track_done when a non-looping track runs out.
module beat_sequencer_ctrl #(
    parameter int NUM_TRACKS = 4,
    parameter int TRACK_LEN  = 92,
    parameter int BEAT_DIV   = 12500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_TRACKS-1:0] pad_req,
    input  logic                  play_pause,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [1:0]            speed,
    output logic [25:0]           ibeatNum,
    output logic [NUM_TRACKS-1:0] track_en,
    output logic                  pause,
    output logic                  busy,
    output logic                  track_done
);

    localparam int SEL_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int DIV_W = $clog2(BEAT_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_FULL  = DIV_W'(BEAT_DIV);
    localparam logic [25:0]      LAST_BEAT = 26'(TRACK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSED
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [DIV_W-1:0] divider;

    logic [SEL_W-1:0] pad_idx;
    logic             pad_any;
    logic [1:0]       shift;
    logic [DIV_W-1:0] period_m1;
    logic             tick;

    assign pad_any = |pad_req;

    // Lowest-indexed pad wins when several are pressed in the same cycle.
    always_comb begin
        // NOTE: default assignment first so the loop never leaves pad_idx unassigned (no latch).
        pad_idx = '0;
        for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
            if (pad_req[i]) begin
                pad_idx = SEL_W'(i);
            end
        end
    end

    // Beat period in clk cycles; speed 3 is clamped to speed 2. Comparing with
    // >= lets a speed-up mid-beat tick immediately instead of overrunning.
    always_comb begin
        shift     = (speed == 2'd3) ? 2'd2 : speed;
        period_m1 = (DIV_FULL >> shift) - DIV_W'(1);
        tick      = (divider >= period_m1);
    end

    // Playback FSM with registered outputs; stop > pad_req > play_pause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            divider    <= '0;
            ibeatNum   <= '0;
            track_en   <= '0;
            pause      <= 1'b0;
            busy       <= 1'b0;
            track_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            track_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pad_any) begin
                        state    <= PLAY;
                        sel      <= pad_idx;
                        divider  <= '0;
                        ibeatNum <= '0;
                        track_en <= NUM_TRACKS'(1) << pad_idx;
                        pause    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                PLAY: begin
                    if (stop) begin
                        state    <= IDLE;
                        divider  <= '0;
                        ibeatNum <= '0;
                        track_en <= '0;
                        pause    <= 1'b0;
                        busy     <= 1'b0;
                    end else if (pad_any) begin
                        sel      <= pad_idx;
                        divider  <= '0;
                        ibeatNum <= '0;
                        track_en <= NUM_TRACKS'(1) << pad_idx;
                    end else if (play_pause) begin
                        state <= PAUSED;
                        pause <= 1'b1;
                    end else if (tick) begin
                        divider <= '0;
                        if (ibeatNum < LAST_BEAT) begin
                            ibeatNum <= ibeatNum + 26'd1;
                        end else if (loop_en) begin
                            ibeatNum <= '0;
                        end else begin
                            state      <= IDLE;
                            ibeatNum   <= '0;
                            track_en   <= '0;
                            busy       <= 1'b0;
                            track_done <= 1'b1;
                        end
                    end else begin
                        divider <= divider + DIV_W'(1);
                    end
                end

                PAUSED: begin
                    if (stop) begin
                        state    <= IDLE;
                        divider  <= '0;
                        ibeatNum <= '0;
                        track_en <= '0;
                        pause    <= 1'b0;
                        busy     <= 1'b0;
                    end else if (pad_any) begin
                        state    <= PLAY;
                        sel      <= pad_idx;
                        divider  <= '0;
                        ibeatNum <= '0;
                        track_en <= NUM_TRACKS'(1) << pad_idx;
                        pause    <= 1'b0;
                    end else if (play_pause) begin
                        state <= PLAY;
                        pause <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    divider  <= '0;
                    ibeatNum <= '0;
                    track_en <= '0;
                    pause    <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beat_sequencer_ctrl.sv
// tb_beat_sequencer_ctrl
// Directed bench for beat_sequencer_ctrl with BEAT_DIV=4, TRACK_LEN=8 and
// NUM_TRACKS=4. Inputs change 1 ns after a rising edge; outputs are sampled
// at the same point.
module tb_beat_sequencer_ctrl;

    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NT-1:0] pad_req = '0;
    logic          play_pause = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [1:0]    speed = 2'd0;
    logic [25:0]   ibeatNum;
    logic [NT-1:0] track_en;
    logic          pause;
    logic          busy;
    logic          track_done;

    int n_cmp = 0;
    int n_err = 0;

    beat_sequencer_ctrl #(
        .NUM_TRACKS(NT),
        .TRACK_LEN (8),
        .BEAT_DIV  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pad_req   (pad_req),
        .play_pause(play_pause),
        .stop      (stop),
        .loop_en   (loop_en),
        .speed     (speed),
        .ibeatNum  (ibeatNum),
        .track_en  (track_en),
        .pause     (pause),
        .busy      (busy),
        .track_done(track_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_pad(input logic [NT-1:0] m);
        pad_req = m;
        step(1);
        pad_req = '0;
    endtask

    task automatic pulse_pp();
        play_pause = 1'b1;
        step(1);
        play_pause = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_cmp++;
        if ({ibeatNum, track_en, pause, busy, track_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: beat=%0d en=%b pause=%b busy=%b done=%b, want all 0",
                     ibeatNum, track_en, pause, busy, track_done);
        end
        rst = 1'b0;
        step(1);
        n_cmp++;
        if (busy !== 1'b0 || track_en !== '0) begin
            n_err++;
            $display("FAIL reset_release_idle: busy=%b en=%b, want 0/0000", busy, track_en);
        end
    endtask

    task automatic test_play_once();
        speed = 2'd0;
        loop_en = 1'b0;
        pulse_pad(4'b0010);
        n_cmp++;
        if (track_en !== 4'b0010 || ibeatNum !== 26'd0 || busy !== 1'b1 || pause !== 1'b0) begin
            n_err++;
            $display("FAIL start_track1: en=%b beat=%0d busy=%b pause=%b, want 0010/0/1/0",
                     track_en, ibeatNum, busy, pause);
        end
        for (int b = 1; b <= 7; b++) begin
            step(3);
            n_cmp++;
            if (ibeatNum !== 26'(b - 1)) begin
                n_err++;
                $display("FAIL beat_hold_%0d: beat=%0d, want %0d", b, ibeatNum, b - 1);
            end
            step(1);
            n_cmp++;
            if (ibeatNum !== 26'(b)) begin
                n_err++;
                $display("FAIL beat_adv_%0d: beat=%0d, want %0d", b, ibeatNum, b);
            end
        end
        step(3);
        n_cmp++;
        if (ibeatNum !== 26'd7 || track_done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL last_beat_hold: beat=%0d done=%b busy=%b, want 7/0/1",
                     ibeatNum, track_done, busy);
        end
        step(1);
        n_cmp++;
        if (track_done !== 1'b1 || busy !== 1'b0 || track_en !== '0 || ibeatNum !== 26'd0) begin
            n_err++;
            $display("FAIL track_end: done=%b busy=%b en=%b beat=%0d, want 1/0/0000/0",
                     track_done, busy, track_en, ibeatNum);
        end
        step(1);
        n_cmp++;
        if (track_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_single_pulse: done=%b busy=%b, want 0/0", track_done, busy);
        end
    endtask

    task automatic test_loop();
        bit saw_done;
        loop_en = 1'b1;
        pulse_pad(4'b0010);
        saw_done = 1'b0;
        for (int k = 0; k < 28; k++) begin
            step(1);
            if (track_done) saw_done = 1'b1;
        end
        n_cmp++;
        if (ibeatNum !== 26'd7) begin
            n_err++;
            $display("FAIL loop_reach_last: beat=%0d, want 7", ibeatNum);
        end
        for (int k = 0; k < 4; k++) begin
            step(1);
            if (track_done) saw_done = 1'b1;
        end
        n_cmp++;
        if (ibeatNum !== 26'd0 || track_en !== 4'b0010 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL loop_wrap: beat=%0d en=%b busy=%b, want 0/0010/1",
                     ibeatNum, track_en, busy);
        end
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (track_done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0 || ibeatNum !== 26'd2) begin
            n_err++;
            $display("FAIL loop_no_done: saw_done=%b beat=%0d, want 0/2", saw_done, ibeatNum);
        end
        pulse_stop();
        loop_en = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || track_en !== '0 || ibeatNum !== 26'd0) begin
            n_err++;
            $display("FAIL loop_stop: busy=%b en=%b beat=%0d, want 0/0000/0",
                     busy, track_en, ibeatNum);
        end
    endtask

    task automatic test_pause();
        bit bad;
        pulse_pad(4'b0001);
        step(14);
        n_cmp++;
        if (ibeatNum !== 26'd3) begin
            n_err++;
            $display("FAIL pause_setup: beat=%0d, want 3", ibeatNum);
        end
        pulse_pp();
        n_cmp++;
        if (pause !== 1'b1 || busy !== 1'b1 || track_en !== 4'b0001) begin
            n_err++;
            $display("FAIL pause_enter: pause=%b busy=%b en=%b, want 1/1/0001",
                     pause, busy, track_en);
        end
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (ibeatNum !== 26'd3 || pause !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL pause_freeze: frozen=%b beat=%0d, want frozen at 3", !bad, ibeatNum);
        end
        pulse_pp();
        n_cmp++;
        if (pause !== 1'b0 || ibeatNum !== 26'd3) begin
            n_err++;
            $display("FAIL resume: pause=%b beat=%0d, want 0/3", pause, ibeatNum);
        end
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd3) begin
            n_err++;
            $display("FAIL resume_div3: beat=%0d, want 3", ibeatNum);
        end
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd4) begin
            n_err++;
            $display("FAIL resume_tick: beat=%0d, want 4", ibeatNum);
        end
        pulse_pp();
        pulse_pad(4'b1000);
        n_cmp++;
        if (pause !== 1'b0 || track_en !== 4'b1000 || ibeatNum !== 26'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pause_pad: pause=%b en=%b beat=%0d busy=%b, want 0/1000/0/1",
                     pause, track_en, ibeatNum, busy);
        end
        pulse_pp();
        pulse_stop();
        n_cmp++;
        if (busy !== 1'b0 || pause !== 1'b0 || track_en !== '0) begin
            n_err++;
            $display("FAIL pause_stop: busy=%b pause=%b en=%b, want 0/0/0000",
                     busy, pause, track_en);
        end
    endtask

    task automatic test_multi_pad();
        pulse_pp();
        n_cmp++;
        if (busy !== 1'b0 || pause !== 1'b0) begin
            n_err++;
            $display("FAIL idle_pp_ignored: busy=%b pause=%b, want 0/0", busy, pause);
        end
        pulse_pad(4'b1100);
        n_cmp++;
        if (track_en !== 4'b0100) begin
            n_err++;
            $display("FAIL lowest_pad: en=%b, want 0100", track_en);
        end
        step(3);
        pulse_pad(4'b0001);
        n_cmp++;
        if (ibeatNum !== 26'd0 || track_en !== 4'b0001) begin
            n_err++;
            $display("FAIL retrigger_on_tick: beat=%0d en=%b, want 0/0001", ibeatNum, track_en);
        end
        step(3);
        n_cmp++;
        if (ibeatNum !== 26'd0) begin
            n_err++;
            $display("FAIL retrigger_div_clear: beat=%0d, want 0", ibeatNum);
        end
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd1) begin
            n_err++;
            $display("FAIL retrigger_first_tick: beat=%0d, want 1", ibeatNum);
        end
        pulse_stop();
    endtask

    task automatic test_stop_reset();
        pulse_pad(4'b0001);
        step(5);
        stop = 1'b1;
        pad_req = 4'b0001;
        step(1);
        stop = 1'b0;
        pad_req = '0;
        n_cmp++;
        if ({ibeatNum, track_en, pause, busy, track_done} !== '0) begin
            n_err++;
            $display("FAIL stop_over_pad: beat=%0d en=%b pause=%b busy=%b done=%b, want all 0",
                     ibeatNum, track_en, pause, busy, track_done);
        end
        pulse_pad(4'b0100);
        step(6);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ibeatNum, track_en, pause, busy, track_done} !== '0) begin
            n_err++;
            $display("FAIL async_reset: beat=%0d en=%b pause=%b busy=%b done=%b, want all 0",
                     ibeatNum, track_en, pause, busy, track_done);
        end
        #2;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_speed();
        speed = 2'd2;
        pulse_pad(4'b0010);
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd1) begin
            n_err++;
            $display("FAIL speed2_a: beat=%0d, want 1", ibeatNum);
        end
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd2) begin
            n_err++;
            $display("FAIL speed2_b: beat=%0d, want 2", ibeatNum);
        end
        speed = 2'd3;
        step(2);
        n_cmp++;
        if (ibeatNum !== 26'd4) begin
            n_err++;
            $display("FAIL speed3_clamp: beat=%0d, want 4", ibeatNum);
        end
        pulse_stop();
        speed = 2'd0;
        pulse_pad(4'b0010);
        step(2);
        speed = 2'd1;
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd1) begin
            n_err++;
            $display("FAIL speed_up_tick: beat=%0d, want 1", ibeatNum);
        end
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd1) begin
            n_err++;
            $display("FAIL speed1_hold: beat=%0d, want 1", ibeatNum);
        end
        step(1);
        n_cmp++;
        if (ibeatNum !== 26'd2) begin
            n_err++;
            $display("FAIL speed1_tick: beat=%0d, want 2", ibeatNum);
        end
        pulse_stop();
        speed = 2'd0;
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_loop();
        test_pause();
        test_multi_pad();
        test_stop_reset();
        test_speed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
